// File: rtl/serial_addsub8_pkg.sv
// Shared definitions for the digit-serial add/sub datapath.
package serial_addsub8_pkg;

  // Width of one processed digit; the slice is always 2 bits wide.
  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub8_slice.sv
// 2-bit add/sub cell: SUM = A + (B ^ {S,S}) + CIN, with internal carries exposed.
module addsub2_slice (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       S,
  input  logic       CIN,
  output logic [1:0] SUM,
  output logic       C1,
  output logic       C2
);

  logic [1:0] bx;

  // Ripple the two bits; C1 is kept visible so the caller can form signed overflow.
  always_comb begin
    bx     = B ^ {S, S};
    SUM    = 2'b00;
    C1     = 1'b0;
    C2     = 1'b0;
    {C1, SUM[0]} = {1'b0, A[0]} + {1'b0, bx[0]} + {1'b0, CIN};
    {C2, SUM[1]} = {1'b0, A[1]} + {1'b0, bx[1]} + {1'b0, C1};
  end

endmodule

// File: rtl/serial_addsub8.sv
// Digit-serial two's-complement adder/subtractor built around one addsub2_slice.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for START; operands latched on acceptance
//   ST_RUN  | one digit per cycle through the slice, LSB digit first
//   ST_DONE | one-cycle completion pulse, results already registered
module serial_addsub8
  import serial_addsub8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             COUT,
  output logic             OVF
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  // A single-digit configuration still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh, b_sh, res;
  logic               sub, carry;
  logic [1:0]         sum;
  logic               c1, c2;
  logic               last_digit;
  logic [WIDTH+1:0]   res_cat;
  logic [WIDTH-1:0]   res_nxt;

  addsub2_slice u_slice (
    .A   (a_sh[1:0]),
    .B   (b_sh[1:0]),
    .S   (sub),
    .CIN (carry),
    .SUM (sum),
    .C1  (c1),
    .C2  (c2)
  );

  // New digit enters at the top; after NDIG shifts digit 0 sits at the bottom.
  always_comb begin
    res_cat    = {sum, res};
    res_nxt    = res_cat[WIDTH+1:2];
    last_digit = (state == ST_RUN) && (cnt == LAST);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always falls back to IDLE without looking at START.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (START)      state_nxt = ST_RUN;
      ST_RUN:  if (last_digit) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Operand shifting, digit counting, carry chaining and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      sub   <= 1'b0;
      carry <= 1'b0;
      res   <= '0;
      Y     <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (START) begin
            a_sh  <= A;
            b_sh  <= B;
            sub   <= S;
            // Subtract needs the +1 of two's complement; it rides in as carry-in.
            carry <= S;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> DIGIT_W;
          b_sh  <= b_sh >> DIGIT_W;
          res   <= res_nxt;
          carry <= c2;
          if (last_digit) begin
            cnt  <= '0;
            Y    <= res_nxt;
            COUT <= c2;
            OVF  <= c1 ^ c2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Both flags decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    BUSY = (state == ST_RUN);
    DONE = (state == ST_DONE);
  end

endmodule

// File: tb/tb_serial_addsub8.sv
// Self-checking bench for serial_addsub8 (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub8;

  localparam int W    = 8;
  localparam int NDIG = W / 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         S = 1'b0;
  logic         BUSY, DONE, COUT, OVF;
  logic [W-1:0] Y;

  int tests  = 0;
  int failed = 0;

  serial_addsub8 #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .S(S),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .COUT(COUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge: inputs set here are stable for the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    int unsigned full;
    logic [W-1:0] y;
    logic cout, ovf;
    if (s) full = int'(a) + int'((~b) & 8'hFF) + 1;
    else   full = int'(a) + int'(b);
    y    = full[W-1:0];
    cout = full[W];
    if (s) ovf = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
    else   ovf = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    return {ovf, cout, y};
  endfunction

  task automatic check_outs(input string name, input logic busy_e, input logic done_e,
                            input logic [W-1:0] y_e, input logic cout_e, input logic ovf_e);
    tests++;
    if ({BUSY, DONE, Y, COUT, OVF} !== {busy_e, done_e, y_e, cout_e, ovf_e}) begin
      failed++;
      $display("FAIL %s: got busy=%b done=%b y=%h cout=%b ovf=%b, want busy=%b done=%b y=%h cout=%b ovf=%b",
               name, BUSY, DONE, Y, COUT, OVF, busy_e, done_e, y_e, cout_e, ovf_e);
    end
  endtask

  // Runs one operation starting in the current cycle (N) and checks every cycle to N+6.
  // Operand inputs are scrambled after acceptance to prove they were latched.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    logic [W+1:0] exp;
    exp = model(a, b, s);
    A = a; B = b; S = s; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 1; i <= NDIG; i++) begin
      A = W'($urandom); B = W'($urandom); S = 1'($urandom);
      tests++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        failed++;
        $display("FAIL %s busy N+%0d: got busy=%b done=%b, want busy=1 done=0", name, i, BUSY, DONE);
      end
      tick();
    end
    check_outs({name, " done"}, 1'b0, 1'b1, exp[W-1:0], exp[W], exp[W+1]);
    tick();
    check_outs({name, " hold"}, 1'b0, 1'b0, exp[W-1:0], exp[W], exp[W+1]);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    check_outs("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    check_outs("post reset idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_directed();
    run_op("add 5a+3c", 8'h5A, 8'h3C, 1'b0);
    run_op("sub 10-01", 8'h10, 8'h01, 1'b1);
    run_op("sub 00-01", 8'h00, 8'h01, 1'b1);
    run_op("sub 80-01", 8'h80, 8'h01, 1'b1);
    run_op("add ff+01", 8'hFF, 8'h01, 1'b0);
    run_op("add 7f+01", 8'h7F, 8'h01, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_op("random", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    // run_op leaves us in N+6, the earliest cycle a new START is accepted.
    run_op("b2b first", 8'h33, 8'h44, 1'b0);
    run_op("b2b second", 8'h20, 8'h50, 1'b1);
  endtask

  task automatic test_start_ignored();
    logic [W+1:0] exp;
    int extra;
    exp = model(8'h12, 8'h34, 1'b0);
    A = 8'h12; B = 8'h34; S = 1'b0; START = 1'b1;   // cycle N
    tick();
    START = 1'b0;                                    // N+1
    tick();
    A = 8'hF0; B = 8'h0F; S = 1'b1; START = 1'b1;   // N+2, in RUN
    tick();
    START = 1'b0;                                    // N+3
    tick();                                          // N+4
    tick();                                          // N+5, DONE
    A = 8'h99; B = 8'h11; S = 1'b1; START = 1'b1;
    check_outs("ignored first result", 1'b0, 1'b1, exp[W-1:0], exp[W], exp[W+1]);
    tick();
    START = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE === 1'b1 || BUSY === 1'b1) extra++;
      tick();
    end
    tests++;
    if (extra != 0) begin
      failed++;
      $display("FAIL ignored no second op: got %0d busy/done cycles, want 0", extra);
    end
    check_outs("ignored hold", 1'b0, 1'b0, exp[W-1:0], exp[W], exp[W+1]);
  endtask

  task automatic test_reset_mid();
    run_op("pre reset", 8'hC3, 8'h5A, 1'b0);        // leave nonzero results behind
    A = 8'h6D; B = 8'h2B; S = 1'b1; START = 1'b1;   // N
    tick();
    START = 1'b0;                                    // N+1
    tick();
    RST = 1'b1;                                      // N+2
    tick();
    RST = 1'b0;                                      // N+3
    check_outs("mid reset clears", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();                                          // N+4
    run_op("after reset", 8'h6D, 8'h2B, 1'b1);       // DONE lands in N+9
    // RST and START together: reset wins and nothing starts.
    A = 8'h01; B = 8'h01; S = 1'b0; START = 1'b1; RST = 1'b1;
    tick();
    START = 1'b0; RST = 1'b0;
    check_outs("reset beats start", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    check_outs("reset beats start later", 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
